// File: rtl/button_request.sv
// Debounces a synchronized button/sensor line and emits a press pulse, a pending
// request flag held until acknowledged, and a saturating press counter.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | debounced level low, input low
// RISE_WAIT | input high, counting stable high samples
// HELD      | debounced level high, input high
// FALL_WAIT | input low, counting stable low samples
module button_request #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_sync,
  input  logic       ack,
  input  logic       clear_count,
  output logic       level,
  output logic       press_pulse,
  output logic       req,
  output logic [7:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HELD      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             req_q, req_d;
  logic [7:0]       count_q, count_d;
  logic             rise_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      req_q   <= req_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (sig_sync) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RISE_WAIT: begin
        if (!sig_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          rise_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sig_sync) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (sig_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new press beats a simultaneous ack; a clear beats a simultaneous increment.
  always_comb begin
    level_d = (state_d == HELD) || (state_d == FALL_WAIT);
    pulse_d = rise_evt;
    req_d   = req_q;
    if (rise_evt) begin
      req_d = 1'b1;
    end else if (ack && req_q) begin
      req_d = 1'b0;
    end
    count_d = count_q;
    if (clear_count) begin
      count_d = 8'd0;
    end else if (rise_evt && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;
  assign req         = req_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_request.sv
// Directed bench for button_request with DEBOUNCE_CYCLES=4; inputs change 1 ns
// after each rising edge and outputs are checked at the same point.
module tb_button_request;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_sync;
  logic       ack;
  logic       clear_count;
  logic       level;
  logic       press_pulse;
  logic       req;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_pass   = 0;

  button_request #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_sync    (sig_sync),
    .ack         (ack),
    .clear_count (clear_count),
    .level       (level),
    .press_pulse (press_pulse),
    .req         (req),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks n cycles, returning the number of pulses seen and whether level ever dropped.
  task automatic run(input int n, output int pulses, output int level_lows);
    pulses = 0;
    level_lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (press_pulse) pulses++;
      if (!level) level_lows++;
    end
  endtask

  task automatic press_release();
    sig_sync = 1'b1;
    repeat (4) tick();
    sig_sync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int pulses;
    int lows;
    int any_high;
    logic [10:0] bounce;

    rst = 1'b1;
    sig_sync = 1'b1;
    ack = 1'b0;
    clear_count = 1'b0;

    // Reset with input held high
    tick();
    check("rst_outputs_c1", {level, press_pulse, req, press_count}, 32'd0);
    tick();
    check("rst_outputs_c2", {level, press_pulse, req, press_count}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_level_after3", level, 1'b0);
    tick();
    check("rst_level_after4", level, 1'b1);
    check("rst_pulse_after4", press_pulse, 1'b1);
    check("rst_count", press_count, 8'd1);
    check("rst_req", req, 1'b1);
    tick();
    check("rst_pulse_one_cycle", press_pulse, 1'b0);

    // Release, then handshake
    sig_sync = 1'b0;
    repeat (3) tick();
    check("rel_level_after3", level, 1'b1);
    tick();
    check("rel_level_after4", level, 1'b0);
    check("rel_no_pulse", press_pulse, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_clears_req", req, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_idle_req", req, 1'b0);
    check("ack_idle_count", press_count, 8'd1);

    // Clean press: 10 high, 10 low
    sig_sync = 1'b1;
    repeat (3) tick();
    check("clean_level_after3", level, 1'b0);
    check("clean_pulse_after3", press_pulse, 1'b0);
    tick();
    check("clean_pulse_after4", press_pulse, 1'b1);
    run(6, pulses, lows);
    check("clean_extra_pulses", pulses, 0);
    check("clean_req", req, 1'b1);
    check("clean_count", press_count, 8'd2);
    sig_sync = 1'b0;
    run(3, pulses, lows);
    check("clean_level_fall3", level, 1'b1);
    tick();
    check("clean_level_fall4", level, 1'b0);
    run(6, pulses, lows);
    check("clean_release_pulses", pulses + (press_pulse ? 1 : 0), 0);

    // Bounce pattern never qualifies
    ack = 1'b1;
    tick();
    ack = 1'b0;
    bounce = 11'b11101110000;
    any_high = 0;
    for (int i = 10; i >= 0; i--) begin
      sig_sync = bounce[i];
      tick();
      if (level || press_pulse || req) any_high++;
    end
    check("bounce_outputs", any_high, 0);
    check("bounce_count", press_count, 8'd2);

    // Release glitch while held
    sig_sync = 1'b1;
    repeat (4) tick();
    check("glitch_held", level, 1'b1);
    check("glitch_count", press_count, 8'd3);
    sig_sync = 1'b0;
    run(3, pulses, lows);
    sig_sync = 1'b1;
    tick();
    if (press_pulse) pulses++;
    if (!level) lows++;
    check("glitch_level_low_cycles", lows, 0);
    check("glitch_pulses", pulses, 0);
    sig_sync = 1'b0;
    repeat (3) tick();
    check("glitch_fall_after3", level, 1'b1);
    tick();
    check("glitch_fall_after4", level, 1'b0);

    // Ack on the same edge as a new press: set wins
    check("same_edge_req_before", req, 1'b1);
    sig_sync = 1'b1;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("same_edge_req", req, 1'b1);
    check("same_edge_pulse", press_pulse, 1'b1);
    check("same_edge_count", press_count, 8'd4);
    sig_sync = 1'b0;
    repeat (4) tick();

    // Clear pulse, then clear coinciding with a press
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clear_pulse", press_count, 8'd0);
    sig_sync = 1'b1;
    repeat (3) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clear_vs_inc_count", press_count, 8'd0);
    check("clear_vs_inc_pulse", press_pulse, 1'b1);
    sig_sync = 1'b0;
    repeat (4) tick();

    // Saturation
    for (int p = 0; p < 254; p++) press_release();
    check("count_254", press_count, 8'd254);
    press_release();
    check("count_255", press_count, 8'd255);
    for (int p = 0; p < 5; p++) press_release();
    check("count_saturated", press_count, 8'd255);

    // Reset mid RISE_WAIT
    sig_sync = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", {level, press_pulse, req, press_count}, 32'd0);
    repeat (3) tick();
    check("mid_rst_level_after3", level, 1'b0);
    tick();
    check("mid_rst_level_after4", level, 1'b1);
    check("mid_rst_count", press_count, 8'd1);
    sig_sync = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_request.md
# button_request

Debounces one already-synchronized push-button or vehicle-sensor line, emits a single-cycle press pulse, and holds a pending-request flag until the traffic controller acknowledges it. Sits directly downstream of the two-flop synchronizer: its `sig_sync` input is that stage's output. Its outputs go to the intersection controller FSM, which consumes `req` and replies with `ack`. A saturating press counter is kept for diagnostics and display.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000 (20 ms at 100 MHz): consecutive stable samples required to change the debounced level. Legal range 2 to 2^24.
- `CNT_W`, localparam, `$clog2(DEBOUNCE_CYCLES+1)`: stability counter width. Not overridable.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `sig_sync`  in  1  synchronized raw input (1 = pressed/occupied).
- `ack`  in  1  controller acknowledge; clears `req`.
- `clear_count`  in  1  synchronous clear of `press_count`.
- `level`  out  1  debounced input level.
- `press_pulse`  out  1  one-cycle strobe on each debounced rising edge.
- `req`  out  1  pending request flag.
- `press_count`  out  8  saturating count of debounced presses.

## Operation
- Four-state FSM, all outputs registered: IDLE (level 0), RISE_WAIT (level 0), HELD (level 1), FALL_WAIT (level 1).
- **IDLE**
  - `sig_sync`=1: go to RISE_WAIT, cnt<=1.
  - Otherwise: stay, cnt<=0.
- **RISE_WAIT**
  - `sig_sync`=0: go to IDLE, cnt<=0.
  - `sig_sync`=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD; `level`<=1, `press_pulse`<=1, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- **HELD**
  - `sig_sync`=0: go to FALL_WAIT, cnt<=1.
  - Otherwise: stay.
- **FALL_WAIT**
  - `sig_sync`=1: go back to HELD, cnt<=0. No pulse is generated.
  - `sig_sync`=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE; `level`<=0, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- `press_pulse` is 1 only on the single cycle following the RISE_WAIT to HELD edge. It is 0 at all other times.
- A release never produces a pulse.
- **`req` rules**
  - Set on any edge where the FSM takes RISE_WAIT to HELD.
  - Cleared on an edge where `ack`=1 and `req`=1.
  - Set and clear on the same edge: set wins and `req` stays 1, because the new press is a new request.
  - `ack` while `req`=0 is ignored.
- **`press_count` rules**
  - Increments by 1 on each RISE_WAIT to HELD edge.
  - Saturates at 255 with no wrap.
  - `clear_count`=1 forces it to 0. If an increment falls on the same edge, clear wins and the result is 0.
- **Reset** (`rst`=1 on any edge, including mid-count):
  - state IDLE, cnt 0;
  - `level`, `press_pulse`, `req` = 0;
  - `press_count` = 0.
- An input held high through reset is re-debounced from scratch. It produces one press DEBOUNCE_CYCLES edges after the first high sample with `rst`=0.

## Timing
- **Rise latency:** `level`, `press_pulse` and `req` become 1 after the DEBOUNCE_CYCLES-th consecutive edge sampling `sig_sync`=1. The first such sample is the IDLE edge.
- **Fall latency:** `level` becomes 0 after the DEBOUNCE_CYCLES-th consecutive edge sampling `sig_sync`=0 while in HELD or FALL_WAIT.
- **`ack`:** `req` falls the cycle after `ack` is sampled. The controller may hold `ack` high for multiple cycles with no side effect.
- **No combinational paths:** there is no path from any input to any output.
- **Pulse spacing:** minimum spacing between two `press_pulse` strobes is 2*DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert `rst` for 2 cycles with `sig_sync`=1. Required: all outputs 0 during reset; `level` and `press_pulse` become 1 exactly after the 4th post-reset high sample; `press_count`=1.
- **Clean press:** `sig_sync`=1 for 10 cycles, then 0 for 10 cycles. Required:
  - `press_pulse` high for exactly one cycle, after the 4th high sample;
  - `req`=1, `press_count`=1;
  - `level` falls after the 4th low sample with no pulse on release.
- **Bounce:** pattern 1,1,1,0,1,1,1,0,0,0,0. Required: `level`, `press_pulse`, `req` never assert; `press_count` stays 0.
- **Release glitch:** while HELD, drive `sig_sync`=0 for 3 cycles, then 1. Required: `level` stays 1 and no second pulse. Then drive 0 for 4 cycles. Required: `level` becomes 0.
- **Handshake:**
  - `ack` 1 cycle with `req`=1: `req` 0 next cycle.
  - `ack` with `req`=0: no change.
  - `ack` on the same edge as a new press: `req` stays 1.
- **Counter:**
  - 260 clean presses: `press_count`=255.
  - `clear_count` pulse: 0.
  - `clear_count` coinciding with a press: 0.
  - `rst` mid RISE_WAIT (cnt=2): next press still needs 4 high samples.
